b_resp_sched: RTL

AXI write-response (B channel) scheduler for the AXI-to-AHB bridge, on the read side of the response FIFO. It records the AWID of every accepted write burst in an internal in-order ID queue. It pops one 2-bit AHB response per burst from the response FIFO. It presents the matching {BID, BRESP} to the AXI master with a VALID/READY handshake. All logic is on one clock, the bridge's AXI-side clock.

---
 rtl/b_resp_sched.sv | 111 +++++++++++
 1 files changed

// File: rtl/b_resp_sched.sv
// AXI B-channel scheduler: in-order AWID queue paired with AHB responses popped from the response FIFO.
// Latency: fifo_rd_en in cycle N gives bvalid in N+1, and bready in N gives bvalid low in N+1 (1 response per 2 cycles).
// Backpressure: bvalid/bid/bresp hold until bready; aw_ready drops at DEPTH outstanding; B_RESP_SCHED_ERR_MAP_EN remaps AHB codes to AXI.
module b_resp_sched #(
    parameter int ID_W  = 4,
    parameter int DEPTH = 8,
    localparam int PW   = $clog2(DEPTH)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            aw_push,
    input  logic [ID_W-1:0] aw_id,
    output logic            aw_ready,
    input  logic            fifo_empty,
    output logic            fifo_rd_en,
    input  logic [1:0]      fifo_data,
    output logic            bvalid,
    input  logic            bready,
    output logic [ID_W-1:0] bid,
    output logic [1:0]      bresp,
    output logic [PW:0]     outstanding
);

    localparam logic [PW:0] CNT_FULL = (PW+1)'(DEPTH);

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_VALID = 1'b1
    } state_t;

    state_t          state;
    logic [ID_W-1:0] id_mem [DEPTH];
    logic [PW-1:0]   wr_ptr;
    logic [PW-1:0]   rd_ptr;
    logic [PW:0]     cnt;
    logic            do_push;
    logic            do_pop;
    logic [1:0]      resp_mapped;

    assign aw_ready    = (cnt != CNT_FULL);
    assign do_push     = aw_push && aw_ready;
    assign do_pop      = bvalid && bready;
    assign outstanding = cnt;

    // cnt is registered, so a burst pushed this cycle cannot claim a response until next cycle
    assign fifo_rd_en  = (state == ST_IDLE) && (cnt != '0) && !fifo_empty;

`ifdef B_RESP_SCHED_ERR_MAP_EN
    // AHB ERROR, RETRY and SPLIT all surface to the AXI master as SLVERR
    assign resp_mapped = (fifo_data == 2'b00) ? 2'b00 : 2'b10;
`else
    assign resp_mapped = fifo_data;
`endif

    always_ff @(posedge clk) begin
        if (do_push) begin
            id_mem[wr_ptr] <= aw_id;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   cnt <= cnt + (PW+1)'(1);
                2'b01:   cnt <= cnt - (PW+1)'(1);
                default: cnt <= cnt;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= ST_IDLE;
            bvalid <= 1'b0;
            bid    <= '0;
            bresp  <= 2'b00;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (fifo_rd_en) begin
                        bid    <= id_mem[rd_ptr];
                        bresp  <= resp_mapped;
                        bvalid <= 1'b1;
                        state  <= ST_VALID;
                    end
                end
                ST_VALID: begin
                    if (bready) begin
                        bvalid <= 1'b0;
                        state  <= ST_IDLE;
                    end
                end
                default: begin
                    bvalid <= 1'b0;
                    state  <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
